// File: rtl/alu_mc_mod.sv
// Multi-cycle execute stage: 1-cycle integer/branch/address/U-type ops, iterative MUL (XLEN/MUL_ITER+1) and DIV (XLEN+1).
// Result is held in DONE until out_ready; defining ALU_MC_FAST_MUL_EN makes multiplies single-cycle combinational.
module alu_mc_mod #(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic            br_en,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam int PW  = XLEN + MUL_ITER;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   opb;
  logic              neg_q;
  logic              neg_r;
  logic              hi_sel;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic [XLEN-1:0] imm, op2, alu_res, res_base, sra_res;
  logic [SHW-1:0]  shamt;
  logic            br_take;

  always_comb begin
    imm = XLEN'($signed(inst[31:20]));
    case (opcode)
      OPC_STORE:          imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      OPC_BRANCH:         imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      OPC_LUI, OPC_AUIPC: imm = XLEN'($signed({inst[31:12], 12'h000}));
      default: ;
    endcase
  end

  assign op2     = (opcode == OPC_OPIMM) ? imm : rs2_data;
  assign shamt   = op2[SHW-1:0];
  assign sra_res = $signed(rs1_data) >>> shamt;

  always_comb begin
    alu_res = rs1_data + op2;
    case (funct3)
      3'd0: if (opcode == OPC_OP && inst[30]) alu_res = rs1_data - op2;
      3'd1: alu_res = rs1_data << shamt;
      3'd2: alu_res = XLEN'($signed(rs1_data) < $signed(op2));
      3'd3: alu_res = XLEN'(rs1_data < op2);
      3'd4: alu_res = rs1_data ^ op2;
      3'd5: alu_res = inst[30] ? sra_res : (rs1_data >> shamt);
      3'd6: alu_res = rs1_data | op2;
      3'd7: alu_res = rs1_data & op2;
      default: ;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'd0: br_take = (rs1_data == rs2_data);
      3'd1: br_take = (rs1_data != rs2_data);
      3'd4: br_take = ($signed(rs1_data) < $signed(rs2_data));
      3'd5: br_take = ($signed(rs1_data) >= $signed(rs2_data));
      3'd6: br_take = (rs1_data < rs2_data);
      3'd7: br_take = (rs1_data >= rs2_data);
      default: ;
    endcase
  end

  // M-extension operand conditioning: magnitudes plus the sign flags needed to fix up the result
  logic            is_m, is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, div_spec;
  logic [XLEN-1:0] mag_a, mag_b, div_spec_res;

  assign is_m     = (opcode == OPC_OP) && (funct7 == 7'b0000001);
  assign is_mul   = is_m && !funct3[2];
  assign is_div   = is_m && funct3[2];
  assign a_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
  assign b_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'd1);
  assign a_neg    = a_sgn && rs1_data[XLEN-1];
  assign b_neg    = b_sgn && rs2_data[XLEN-1];
  assign mag_a    = a_neg ? -rs1_data : rs1_data;
  assign mag_b    = b_neg ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  assign div_ovf  = a_sgn && (rs1_data == XMIN) && (rs2_data == '1);
  assign div_spec = div_zero || div_ovf;
  // overflow quotient is MIN, which is the dividend itself
  assign div_spec_res = div_zero ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : rs1_data);

  always_comb begin
    res_base = rs1_data + rs2_data;
    case (opcode)
      OPC_OP, OPC_OPIMM:     res_base = alu_res;
      OPC_LOAD, OPC_STORE:   res_base = rs1_data + imm;
      OPC_BRANCH, OPC_AUIPC: res_base = pc + imm;
      OPC_LUI:               res_base = imm;
      default: ;
    endcase
    if (is_div) res_base = div_spec_res;
  end

  // Multiplier: low half holds the remaining multiplier bits, high half the running sum
  logic [MUL_ITER-1:0] mbits;
  logic [PW-1:0]       psum;
  logic [2*XLEN-1:0]   mul_next, mul_fin;
  logic [XLEN-1:0]     mul_res;

  assign mbits    = prod[MUL_ITER-1:0];
  assign psum     = PW'(prod[2*XLEN-1:XLEN]) + PW'(opb) * PW'(mbits);
  assign mul_next = {psum, prod[XLEN-1:MUL_ITER]};
  assign mul_fin  = neg_q ? -mul_next : mul_next;
  assign mul_res  = hi_sel ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];

  // Restoring divider: high half is the partial remainder, low half shifts dividend out / quotient in
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem, div_res;

  assign shifted  = prod[2*XLEN-1:XLEN-1];
  assign diff     = shifted - {1'b0, opb};
  assign div_next = {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0], prod[XLEN-2:0], !diff[XLEN]};
  assign quo      = div_next[XLEN-1:0];
  assign rem      = div_next[2*XLEN-1:XLEN];
  assign div_res  = hi_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

`ifdef ALU_MC_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_mag  = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  assign fast_res  = (funct3[1:0] != 2'd0) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
`endif

  logic accept;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_sel    <= 1'b0;
      rd_data   <= '0;
      br_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          prod <= mul_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rd_data   <= mul_res;
            br_en     <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DIV: begin
          prod <= div_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rd_data   <= div_res;
            br_en     <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // acceptance only happens from IDLE/DONE, so it cleanly overrides the DONE exit above
      if (accept) begin
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        hi_sel <= is_div ? funct3[1] : (funct3[1:0] != 2'd0);
        if (is_mul) begin
`ifdef ALU_MC_FAST_MUL_EN
          rd_data   <= fast_res;
          br_en     <= 1'b0;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
`else
          prod      <= {{XLEN{1'b0}}, mag_a};
          opb       <= mag_b;
          cnt       <= CW'(XLEN / MUL_ITER);
          out_valid <= 1'b0;
          busy      <= 1'b1;
          state     <= MUL;
`endif
        end else if (is_div && !div_spec) begin
          prod      <= {{XLEN{1'b0}}, mag_a};
          opb       <= mag_b;
          cnt       <= CW'(XLEN);
          out_valid <= 1'b0;
          busy      <= 1'b1;
          state     <= DIV;
        end else begin
          rd_data   <= res_base;
          br_en     <= (opcode == OPC_BRANCH) && br_take;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_mod.sv
// Randomized and directed bench for alu_mc_mod (XLEN=32) against an arithmetic reference model.
module tb_alu_mc_mod;
  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
`ifdef ALU_MC_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, br_en, busy;
  logic [31:0] inst, rs1_data, rs2_data, pc, rd_data;
  int          n_chk = 0;
  int          n_err = 0;

  alu_mc_mod dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data), .br_en(br_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [11:0] im, input logic [2:0] f3);
    return {im, 5'd1, f3, 5'd3, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [2:0] f3);
    return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], BRANCH};
  endfunction

  // Reference: RISC-V semantics from the ISA rules, using 32/64-bit integer arithmetic
  task automatic model(input logic [31:0] ins, a, b, p, output logic [31:0] r, output logic be, output int lat);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] ii, is_, ib, iu, b2;
    int          sa, sb;
    longint      la, lb, ua, ub, pr;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ii  = {{20{ins[31]}}, ins[31:20]};
    is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = {ins[31:12], 12'h000};
    sa = int'(a); sb = int'(b);
    la = sa; lb = sb; ua = {32'h0, a}; ub = {32'h0, b};
    r = a + b; be = 1'b0; lat = 1;
    case (opc)
      OP, OPIMM: begin
        if (opc == OP && f7 == 7'h01 && !f3[2]) begin
          case (f3[1:0])
            2'd0, 2'd1: pr = la * lb;
            2'd2:       pr = la * ub;
            default:    pr = ua * ub;
          endcase
          r = (f3[1:0] == 2'd0) ? pr[31:0] : pr[63:32];
          lat = MUL_LAT;
        end else if (opc == OP && f7 == 7'h01) begin
          if (b == 32'h0) r = f3[1] ? a : 32'hFFFFFFFF;
          else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) r = f3[1] ? 32'h0 : 32'h80000000;
          else begin
            lat = 33;
            case (f3[1:0])
              2'd0:    r = 32'(sa / sb);
              2'd1:    r = a / b;
              2'd2:    r = 32'(sa % sb);
              default: r = a % b;
            endcase
          end
        end else begin
          b2 = (opc == OP) ? b : ii;
          case (f3)
            3'd0: r = (opc == OP && f7 == 7'h20) ? a - b2 : a + b2;
            3'd1: r = a << b2[4:0];
            3'd2: r = (sa < int'(b2)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b2) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b2;
            3'd5: r = ins[30] ? 32'(sa >>> b2[4:0]) : a >> b2[4:0];
            3'd6: r = a | b2;
            default: r = a & b2;
          endcase
        end
      end
      LOAD:  r = a + ii;
      STORE: r = a + is_;
      BRANCH: begin
        r = p + ib;
        case (f3)
          3'd0: be = (a == b);
          3'd1: be = (a != b);
          3'd4: be = (sa < sb);
          3'd5: be = (sa >= sb);
          3'd6: be = (a < b);
          3'd7: be = (a >= b);
          default: be = 1'b0;
        endcase
      end
      LUI:   r = iu;
      AUIPC: r = p + iu;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin
        ins[6:0] = OP;
        ins[31:25] = ((ins[14:12] == 3'd0 || ins[14:12] == 3'd5) && ins[31]) ? 7'h20 : 7'h00;
      end
      2, 3: begin ins[6:0] = OP; ins[31:25] = 7'h01; end
      4: begin
        ins[6:0] = OPIMM;
        if (ins[14:12] == 3'd1) ins[31:25] = 7'h00;
        if (ins[14:12] == 3'd5) ins[31:25] = {1'b0, ins[30], 5'b0};
      end
      5: ins[6:0] = LOAD;
      6: ins[6:0] = STORE;
      7: ins[6:0] = BRANCH;
      8: ins[6:0] = ins[7] ? LUI : AUIPC;
      default: ins[6:0] = JAL;
    endcase
    return ins;
  endfunction

  // One op: present, time the result, check it, optionally stall the consumer, then hand it off
  task automatic run_op(input string tag, input logic [31:0] ins, a, b, p, input int stall, output logic [31:0] got);
    logic [31:0] er;
    logic        eb;
    int          el, cyc, bcnt;
    model(ins, a, b, p, er, eb, el);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; inst = ins; rs1_data = a; rs2_data = b; pc = p; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; inst = $urandom; rs1_data = $urandom; rs2_data = $urandom; pc = $urandom;
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end while (!out_valid && cyc < 200);
    chk({tag, "_latency"}, cyc, el);
    chk({tag, "_busy_cycles"}, bcnt, el - 1);
    chk({tag, "_rd_data"}, rd_data, er);
    chk({tag, "_br_en"}, br_en, eb);
    got = rd_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, rd_data, er);
      chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst = '0; rs1_data = '0; rs2_data = '0; pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_br_en", br_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // back-to-back ADDIs with the consumer always ready
    @(negedge clk);
    in_valid = 1'b1; inst = enc_i(OPIMM, 12'hFF9, 3'd0); rs1_data = 32'd5; out_ready = 1'b1;
    @(posedge clk); #1;
    inst = enc_i(OPIMM, 12'h003, 3'd0); rs1_data = 32'd10;
    @(negedge clk);
    chk("b2b_first_valid", out_valid, 1'b1);
    chk("b2b_first_data", rd_data, 32'hFFFFFFFE);
    chk("b2b_first_br", br_en, 1'b0);
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1'b1);
    chk("b2b_second_data", rd_data, 32'd13);
    @(negedge clk);
    chk("b2b_idle", out_valid, 1'b0);

    run_op("mulh", enc_r(7'h01, 3'd1), 32'h80000000, 32'h80000000, 32'h0, 0, got);
    chk("mulh_value", got, 32'h40000000);
    run_op("div", enc_r(7'h01, 3'd4), 32'hFFFFFFF9, 32'd2, 32'h0, 0, got);
    chk("div_value", got, 32'hFFFFFFFD);
    run_op("rem", enc_r(7'h01, 3'd6), 32'hFFFFFFF9, 32'd2, 32'h0, 0, got);
    chk("rem_value", got, 32'hFFFFFFFF);
    run_op("divu0", enc_r(7'h01, 3'd5), 32'd9, 32'd0, 32'h0, 0, got);
    chk("divu0_value", got, 32'hFFFFFFFF);
    run_op("divovf", enc_r(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, got);
    chk("divovf_value", got, 32'h80000000);
    run_op("removf", enc_r(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, got);
    chk("removf_value", got, 32'h0);
    run_op("bge", enc_b(13'h020, 3'd5), 32'd3, 32'd3, 32'h100, 0, got);
    chk("bge_target", got, 32'h120);
    run_op("bltu", enc_b(13'h020, 3'd6), 32'hFFFFFFFF, 32'd1, 32'h100, 0, got);
    run_op("stall_add", enc_r(7'h00, 3'd0), 32'd40, 32'd2, 32'h0, 5, got);
    chk("stall_add_value", got, 32'd42);

    // flush in the 10th DIV cycle kills the op
    @(negedge clk);
    in_valid = 1'b1; inst = enc_r(7'h01, 3'd4); rs1_data = 32'd1000; rs2_data = 32'd7; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_result", seen, 0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; inst = enc_r(7'h01, 3'd0); rs1_data = 32'h1234; rs2_data = 32'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rd_data", rd_data, 32'h0);
    chk("arst_br_en", br_en, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      run_op("rand", rand_inst(), rand_opnd(), rand_opnd(), $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
